// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the ALU issue controller.
// ALU opcodes, condition codes, NZVC bit positions and the controller FSM states.
package alu_pkg;

   // ALU controller opcodes; encodings 13-15 are illegal.
   typedef enum logic [3:0] {
      OP_PLUS    = 4'd0,
      OP_MINUS   = 4'd1,
      OP_RMINUS  = 4'd2,
      OP_PLUSC   = 4'd3,
      OP_MINUSC  = 4'd4,
      OP_RMINUSC = 4'd5,
      OP_MULT    = 4'd6,
      OP_AND     = 4'd7,
      OP_ORR     = 4'd8,
      OP_EOR     = 4'd9,
      OP_BIC     = 4'd10,
      OP_MVN     = 4'd11,
      OP_RRX     = 4'd12
   } alu_op_t;

   // Condition field codes.
   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_CS = 4'd2,
      COND_CC = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_t;

   // Bit positions inside a {N,Z,V,C} flag vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   // Issue controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Arithmetic ops (PLUS..MULT) produce a meaningful V; logic ops leave V alone.
   function automatic logic is_arith(input logic [3:0] op);
      return (op <= 4'(OP_MULT));
   endfunction

   // Only encodings 0..12 name a real ALU operation.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= 4'(OP_RRX));
   endfunction

endpackage

// File: rtl/alu_cond_check.sv
// alu_cond_check: purely combinational condition-code evaluator.
// Decides whether an op with condition field cond executes given the current {N,Z,V,C}.
// Only instantiated when ALU_COND_EXEC_EN is defined.
module alu_cond_check
   import alu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, v, c;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];
   assign c = flags[FLAG_C];

   // Map each condition code to its flag predicate; AL and the spare code always pass.
   always_comb begin
      // NOTE: a default before the case guarantees pass is assigned on every path, so no latch.
      pass = 1'b1;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences the shared 32-bit ALU between decode and regfile writeback.
// IDLE accepts one op, EXEC holds the ALU drive for the op's latency, WB returns the
// result and updates the architectural NZVC register.
// Optional feature macro: ALU_COND_EXEC_EN (conditional execution against current flags).
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int MULT_CYCLES = 3
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        req_shc,
   input  logic        req_setflags,
   input  logic [3:0]  req_cond,
   input  logic [3:0]  req_rd,
   output logic [3:0]  alu_ctrl,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic        alu_carr,
   output logic        alu_c,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_nzvc,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [3:0]  flags,
   output logic        err
);

   // Counter only needs to hold MULT_CYCLES-1.
   localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

   state_t             state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [3:0]         alu_ctrl_q, alu_ctrl_d;
   logic [31:0]        alu_src1_q, alu_src1_d;
   logic [31:0]        alu_src2_q, alu_src2_d;
   logic               alu_carr_q, alu_carr_d;
   logic               alu_c_q,    alu_c_d;
   logic               setflags_q, setflags_d;
   logic               wb_valid_q, wb_valid_d;
   logic               wb_en_q,    wb_en_d;
   logic [3:0]         wb_rd_q,    wb_rd_d;
   logic [31:0]        wb_data_q,  wb_data_d;
   logic [3:0]         nzvc_q,     nzvc_d;
   logic [3:0]         flags_q,    flags_d;
   logic               err_q,      err_d;

   logic               accept;
   logic               cond_pass;

`ifdef ALU_COND_EXEC_EN
   alu_cond_check u_cond_check (
      .cond  (req_cond),
      .flags (flags_q),
      .pass  (cond_pass)
   );
`else
   // Without conditional execution every legal op runs; the condition field is ignored.
   logic unused_cond;
   assign cond_pass   = 1'b1;
   assign unused_cond = ^req_cond;
`endif

   assign req_ready = (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready;

   // Next-state, ALU drive, writeback and flag computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_ctrl_d = alu_ctrl_q;
      alu_src1_d = alu_src1_q;
      alu_src2_d = alu_src2_q;
      alu_carr_d = alu_carr_q;
      alu_c_d    = alu_c_q;
      setflags_d = setflags_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      nzvc_d     = nzvc_q;
      flags_d    = flags_q;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!is_legal_op(req_op)) begin
                  // Illegal op is consumed and reported; nothing else changes.
                  err_d = 1'b1;
               end else begin
                  alu_ctrl_d = req_op;
                  alu_src1_d = req_src1;
                  alu_src2_d = req_src2;
                  alu_carr_d = flags_q[FLAG_C];
                  alu_c_d    = req_shc;
                  setflags_d = req_setflags;
                  wb_rd_d    = req_rd;
                  cnt_d      = (req_op == OP_MULT) ? CNT_W'(MULT_CYCLES - 1) : '0;
                  if (cond_pass) begin
                     state_d = ST_EXEC;
                  end else begin
                     // Condition failed: report a no-write completion straight away.
                     state_d    = ST_WB;
                     wb_valid_d = 1'b1;
                  end
               end
            end
         end

         ST_EXEC: begin
            if (cnt_q == '0) begin
               wb_data_d  = alu_result;
               nzvc_d     = alu_nzvc;
               wb_valid_d = 1'b1;
               wb_en_d    = 1'b1;
               state_d    = ST_WB;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_WB: begin
            state_d = ST_IDLE;
            // wb_en_q marks an op that really executed; skipped ops never touch flags.
            if (wb_en_q && setflags_q) begin
               flags_d[FLAG_N] = nzvc_q[FLAG_N];
               flags_d[FLAG_Z] = nzvc_q[FLAG_Z];
               flags_d[FLAG_C] = nzvc_q[FLAG_C];
               if (is_arith(alu_ctrl_q)) begin
                  flags_d[FLAG_V] = nzvc_q[FLAG_V];
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State register with synchronous reset; reset aborts any op in flight.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         alu_ctrl_q <= '0;
         alu_src1_q <= '0;
         alu_src2_q <= '0;
         alu_carr_q <= 1'b0;
         alu_c_q    <= 1'b0;
         setflags_q <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         nzvc_q     <= '0;
         flags_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_ctrl_q <= alu_ctrl_d;
         alu_src1_q <= alu_src1_d;
         alu_src2_q <= alu_src2_d;
         alu_carr_q <= alu_carr_d;
         alu_c_q    <= alu_c_d;
         setflags_q <= setflags_d;
         wb_valid_q <= wb_valid_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         nzvc_q     <= nzvc_d;
         flags_q    <= flags_d;
         err_q      <= err_d;
      end
   end

   assign alu_ctrl = alu_ctrl_q;
   assign alu_src1 = alu_src1_q;
   assign alu_src2 = alu_src2_q;
   assign alu_carr = alu_carr_q;
   assign alu_c    = alu_c_q;
   assign wb_valid = wb_valid_q;
   assign wb_en    = wb_en_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign flags    = flags_q;
   assign err      = err_q;

endmodule
